pixel_shifter_palette: RTL and testbench

Serialises display bytes into per-pixel pen numbers according to the active screen mode and resolves each pen, or the border, through the 17-entry ink palette into a 5-bit hardware colour. Sits directly upstream of the colour decoder; its `COLOUR` output drives that stage's `COLOUR` input. Also owns the CPU-written pen-select, ink and mode registers.

---
 rtl/ga_pkg.sv | 7 +
 rtl/palette_regs.sv | 22 ++
 rtl/pixel_shifter_palette.sv | 77 +++++++
 tb/tb_pixel_shifter_palette.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ga_pkg.sv
// ga_pkg: shared mode, register-select and palette constants for the gate-array pixel path
package ga_pkg;
    typedef enum logic [1:0] {MODE0, MODE1, MODE2, MODE3} mode_t;
    typedef enum logic [1:0] {REG_PEN = 2'b00, REG_INK = 2'b01, REG_MODE = 2'b10} reg_sel_t;
    localparam logic [4:0] BORDER_PEN = 5'd16;
    localparam logic [4:0] RESET_INK = 5'h14;
endpackage

// File: rtl/palette_regs.sv
// palette_regs: 17x5 ink register file, one write port and one combinational read port
module palette_regs
    import ga_pkg::*;
#(
    parameter logic [4:0] INIT = RESET_INK
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [4:0] wr_addr,
    input  logic [4:0] wr_data,
    input  logic [4:0] rd_addr,
    output logic [4:0] rd_data
);
    logic [4:0] mem [0:16];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            for (int i = 0; i < 17; i++) mem[i] <= INIT;
        else if (we)
            mem[wr_addr] <= wr_data;
    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/pixel_shifter_palette.sv
// pixel_shifter_palette: serialises display bytes into pens and resolves them through the ink palette.
// Define GA_MODE3_EN to decode mode 3 as a 2-bit mode; otherwise mode 3 behaves as mode 0.
module pixel_shifter_palette
    import ga_pkg::*;
#(
    parameter logic [4:0] RESET_INK = ga_pkg::RESET_INK
) (
    input  logic       CLK_n,
    input  logic       RESET_n,
    input  logic       LOAD,
    input  logic [7:0] VDATA,
    input  logic       DISPEN,
    input  logic       HSYNC,
    input  logic       REG_WE,
    input  logic [7:0] REG_DATA,
    output logic [4:0] COLOUR,
    output logic [1:0] MODE
);
    mode_t      pend_q, mode_q;
    reg_sel_t   sel;
    logic [4:0] pen_sel_q, ink, rd_addr;
    logic [7:0] sr_q;
    logic [1:0] phase_q;
    logic [3:0] pen;
    logic       disp_q, hsync_q, shift, two_bit, unused_bit;

    assign sel        = reg_sel_t'(REG_DATA[7:6]);
    assign unused_bit = REG_DATA[5];
    assign MODE       = mode_q;
`ifdef GA_MODE3_EN
    assign two_bit = mode_q == MODE1 || mode_q == MODE3;
`else
    assign two_bit = mode_q == MODE1;
`endif
    // shift on the last phase of each pixel so the next lookup sees the new pixel
    assign shift   = mode_q == MODE2 ? 1'b1 : mode_q == MODE1 ? phase_q[0] : &phase_q;
    assign pen     = mode_q == MODE2 ? {3'b000, sr_q[7]}
                   : two_bit         ? {2'b00, sr_q[3], sr_q[7]}
                   :                   {sr_q[1], sr_q[5], sr_q[3], sr_q[7]};
    assign rd_addr = disp_q ? {1'b0, pen} : BORDER_PEN;

    palette_regs #(.INIT(RESET_INK)) u_palette (
        .clk    (CLK_n),
        .rst_n  (RESET_n),
        .we     (REG_WE && sel == REG_INK),
        .wr_addr(pen_sel_q),
        .wr_data(REG_DATA[4:0]),
        .rd_addr(rd_addr),
        .rd_data(ink)
    );

    always_ff @(posedge CLK_n or negedge RESET_n)
        if (!RESET_n) begin
            pen_sel_q <= '0;
            pend_q    <= MODE0;
            mode_q    <= MODE0;
            hsync_q   <= 1'b0;
            sr_q      <= '0;
            disp_q    <= 1'b0;
            phase_q   <= '0;
            COLOUR    <= RESET_INK;
        end else begin
            hsync_q <= HSYNC;
            if (HSYNC && !hsync_q) mode_q <= pend_q;
            if (REG_WE && sel == REG_PEN) pen_sel_q <= REG_DATA[4] ? BORDER_PEN : {1'b0, REG_DATA[3:0]};
            if (REG_WE && sel == REG_MODE) pend_q <= mode_t'(REG_DATA[1:0]);
            if (LOAD) begin
                sr_q    <= VDATA;
                disp_q  <= DISPEN;
                phase_q <= '0;
            end else begin
                phase_q <= phase_q + 2'd1;
                if (shift) sr_q <= {sr_q[6:0], 1'b0};
            end
            COLOUR <= ink;
        end
endmodule

// File: tb/tb_pixel_shifter_palette.sv
// tb_pixel_shifter_palette: scoreboard bench for the pixel shifter and palette lookup
module tb_pixel_shifter_palette;
    logic       CLK_n = 1'b0, RESET_n = 1'b0, LOAD = 1'b0, DISPEN = 1'b0, HSYNC = 1'b0, REG_WE = 1'b0;
    logic [7:0] VDATA = '0, REG_DATA = '0;
    logic [4:0] COLOUR;
    logic [1:0] MODE;
    int         vectors = 0, errors = 0;
    logic [4:0] pal_m [0:16];
    logic [1:0] pend_m, mode_m;
    logic [4:0] sel_m;
    logic [4:0] exp_q [$];

    always #5 CLK_n = ~CLK_n;

    pixel_shifter_palette dut (
        .CLK_n(CLK_n), .RESET_n(RESET_n), .LOAD(LOAD), .VDATA(VDATA), .DISPEN(DISPEN),
        .HSYNC(HSYNC), .REG_WE(REG_WE), .REG_DATA(REG_DATA), .COLOUR(COLOUR), .MODE(MODE)
    );

    function automatic logic [3:0] pen_of(input logic [1:0] m, input logic [7:0] s);
        if (m == 2'd2) return {3'b000, s[7]};
        if (m == 2'd1) return {2'b00, s[3], s[7]};
`ifdef GA_MODE3_EN
        if (m == 2'd3) return {2'b00, s[3], s[7]};
`endif
        return {s[1], s[5], s[3], s[7]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 17; i++) pal_m[i] = 5'h14;
        pend_m = 2'd0;
        mode_m = 2'd0;
        sel_m  = 5'd0;
    endtask

    task automatic reg_write(input logic [7:0] d);
        REG_DATA = d;
        REG_WE   = 1'b1;
        @(negedge CLK_n);
        REG_WE   = 1'b0;
        case (d[7:6])
            2'b00:   sel_m = d[4] ? 5'd16 : {1'b0, d[3:0]};
            2'b01:   pal_m[sel_m] = d[4:0];
            2'b10:   pend_m = d[1:0];
            default: ;
        endcase
    endtask

    task automatic hsync_pulse();
        HSYNC = 1'b1;
        @(negedge CLK_n);
        mode_m = pend_m;
        HSYNC  = 1'b0;
        @(negedge CLK_n);
    endtask

    task automatic check_mode(input string name);
        vectors++;
        if (MODE !== mode_m) begin
            errors++;
            $display("FAIL %s: MODE=%0d expected %0d", name, MODE, mode_m);
        end
    endtask

    // pushes the expected colours for the first n pixel cycles, then pops and compares them
    task automatic load_byte(input logic [7:0] v, input logic d, input int n);
        int         h;
        logic [7:0] s;
        logic [4:0] e;
        h = mode_m == 2'd2 ? 1 : mode_m == 2'd1 ? 2 : 4;
        for (int i = 0; i < n; i++) begin
            s = v << (i / h);
            exp_q.push_back(d ? pal_m[pen_of(mode_m, s)] : pal_m[16]);
        end
        VDATA  = v;
        DISPEN = d;
        LOAD   = 1'b1;
        @(negedge CLK_n);
        LOAD   = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK_n);
            e = exp_q.pop_front();
            vectors++;
            if (COLOUR !== e) begin
                errors++;
                $display("FAIL pixel%0d byte=%h mode=%0d disp=%0b: COLOUR=%h expected %h", i, v, mode_m, d, COLOUR, e);
            end
        end
    endtask

    task automatic test_reset();
        model_reset();
        @(negedge CLK_n);
        vectors++;
        if (COLOUR !== 5'h14) begin errors++; $display("FAIL reset_colour: COLOUR=%h expected 14", COLOUR); end
        check_mode("reset_mode");
        RESET_n = 1'b1;
        @(negedge CLK_n);
        load_byte(8'hFF, 1'b1, 8);
    endtask

    task automatic test_mode2_ink();
        reg_write(8'h01);
        reg_write(8'h4A);
        reg_write(8'h82);
        hsync_pulse();
        check_mode("mode2_commit");
        load_byte(8'hA5, 1'b1, 8);
        load_byte(8'h3C, 1'b1, 8);
    endtask

    task automatic test_mode0_pens();
        reg_write(8'h80);
        hsync_pulse();
        check_mode("mode0_commit");
        for (int p = 0; p < 16; p++) begin
            reg_write({4'b0000, 4'(p)});
            reg_write({3'b010, 5'(p)});
        end
        load_byte(8'b1000_0001, 1'b1, 8);
        load_byte(8'h6B, 1'b1, 8);
    endtask

    task automatic test_border();
        reg_write(8'h10);
        reg_write(8'h44);
        load_byte(8'hFF, 1'b0, 8);
        load_byte(8'($urandom_range(0, 255)), 1'b0, 8);
    endtask

    task automatic test_mode1();
        reg_write(8'h81);
        hsync_pulse();
        check_mode("mode1_commit");
        load_byte(8'b1000_1000, 1'b1, 8);
        load_byte(8'($urandom_range(0, 255)), 1'b1, 8);
    endtask

    task automatic test_mode_race();
        reg_write(8'h80);
        hsync_pulse();
        reg_write(8'h82);
        REG_DATA = 8'h81;
        REG_WE   = 1'b1;
        HSYNC    = 1'b1;
        @(negedge CLK_n);
        REG_WE   = 1'b0;
        HSYNC    = 1'b0;
        mode_m   = pend_m;
        pend_m   = 2'd1;
        @(negedge CLK_n);
        check_mode("race_old_pending");
        vectors++;
        if (MODE !== 2'd2) begin errors++; $display("FAIL race_literal: MODE=%0d expected 2", MODE); end
        hsync_pulse();
        check_mode("race_next_hsync");
    endtask

    task automatic test_mode3();
        reg_write(8'h83);
        hsync_pulse();
        check_mode("mode3_commit");
        load_byte(8'hFF, 1'b1, 8);
        load_byte(8'h96, 1'b1, 8);
    endtask

    task automatic test_back_to_back();
        reg_write(8'h80);
        hsync_pulse();
        load_byte(8'h81, 1'b1, 3);
        load_byte(8'h18, 1'b1, 8);
        reg_write(8'h81);
        hsync_pulse();
        load_byte(8'hF0, 1'b1, 1);
        load_byte(8'h5A, 1'b1, 8);
    endtask

    task automatic test_ink_timing();
        reg_write(8'h82);
        hsync_pulse();
        reg_write(8'h01);
        reg_write(8'h4A);
        VDATA  = 8'hFF;
        DISPEN = 1'b1;
        LOAD   = 1'b1;
        @(negedge CLK_n);
        LOAD   = 1'b0;
        @(negedge CLK_n);
        vectors++;
        if (COLOUR !== 5'h0A) begin errors++; $display("FAIL ink_before: COLOUR=%h expected 0a", COLOUR); end
        REG_DATA = 8'h51;
        REG_WE   = 1'b1;
        @(negedge CLK_n);
        REG_WE   = 1'b0;
        pal_m[1] = 5'h11;
        vectors++;
        if (COLOUR !== 5'h0A) begin errors++; $display("FAIL ink_same_edge: COLOUR=%h expected 0a", COLOUR); end
        @(negedge CLK_n);
        vectors++;
        if (COLOUR !== 5'h11) begin errors++; $display("FAIL ink_after: COLOUR=%h expected 11", COLOUR); end
        repeat (5) @(negedge CLK_n);
    endtask

    task automatic test_reset_midline();
        load_byte(8'hFF, 1'b1, 2);
        RESET_n = 1'b0;
        #1;
        model_reset();
        vectors++;
        if (COLOUR !== 5'h14) begin errors++; $display("FAIL midline_reset_colour: COLOUR=%h expected 14", COLOUR); end
        check_mode("midline_reset_mode");
        @(negedge CLK_n);
        RESET_n = 1'b1;
        @(negedge CLK_n);
        load_byte(8'hFF, 1'b0, 8);
        load_byte(8'hFF, 1'b1, 8);
    endtask

    initial begin
        test_reset();
        test_mode2_ink();
        test_mode0_pens();
        test_border();
        test_mode1();
        test_mode_race();
        test_mode3();
        test_back_to_back();
        test_ink_timing();
        test_reset_midline();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
